// File: rtl/csr_mtrap_pkg.sv
// ---------------------------------------------------------------------------
// csr_mtrap_pkg
// Shared constants for the machine-mode trap CSR block: CSR addresses,
// mstatus / mie / mip bit positions, the misa constant, the WFI FSM state
// encodings and a helper that tells whether an address is implemented.
// ---------------------------------------------------------------------------
package csr_mtrap_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mie / mip bit positions (software, timer, external)
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    // RV64I: MXL=2 in the top two bits, extension letter I at bit 8
    localparam logic [63:0] MISA_VALUE = 64'h8000_0000_0000_0100;

    // WFI FSM state encodings
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_SLEEP = 1'b1;

    function automatic logic csr_is_mapped(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE,
            CSR_MINSTRET, CSR_MHARTID: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_mtrap_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// 64-bit free-running counter with an increment enable and a write override.
// A write in the same cycle as an increment wins; the count wraps naturally.
//   clk, rstn : clock, asynchronous active-low reset (count clears to 0)
//   inc_en    : add one at the next edge
//   wr_en     : load wr_data at the next edge (overrides inc_en)
//   wr_data   : value to load
//   count     : current count
// ---------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc_en,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (that would infer a latch).
    always_comb begin
        count_d = count_q;
        if (wr_en) begin
            count_d = wr_data;
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_mtrap.sv
// ---------------------------------------------------------------------------
// csr_mtrap
// Machine-mode trap CSR file and trap sequencer.
//   clk, rstn          : clock, asynchronous active-low reset
//   trapped/mret/wfi   : commit-time events from the exception controller
//   retired            : one instruction retired (minstret increment)
//   ecp/ecause/interupt: trap PC, cause code and interrupt flag
//   *_irq              : raw interrupt lines
//   csr_*              : CSR read/write port; rdata and illegal are combinational
//   sip/tip/eip        : globally and individually enabled pending interrupts
//   redirect_valid/pc  : registered one-cycle front-end redirect
//   sleeping           : pipeline parked in WFI
// ---------------------------------------------------------------------------
module csr_mtrap
    import csr_mtrap_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          PC_WIDTH    = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                trapped,
    input  logic                mret,
    input  logic                wfi,
    input  logic                retired,
    input  logic [PC_WIDTH-1:0] ecp,
    input  logic [3:0]          ecause,
    input  logic                interupt,
    input  logic                ext_irq,
    input  logic                timer_irq,
    input  logic                sw_irq,
    input  logic                csr_rd_en,
    input  logic                csr_wr_en,
    input  logic [11:0]         csr_addr,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                csr_illegal,
    output logic                sip,
    output logic                tip,
    output logic                eip,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                sleeping
);

    // mepc is word aligned: its two low bits always read back as zero
    localparam logic [PC_WIDTH-1:0] MEPC_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    logic                mst_mie_q, mst_mie_d;
    logic                mst_mpie_q, mst_mpie_d;
    logic [2:0]          mie_q, mie_d;            // {MEIE, MTIE, MSIE}
    logic [XLEN-1:0]     mtvec_q, mtvec_d;
    logic [XLEN-1:0]     mscratch_q, mscratch_d;
    logic [PC_WIDTH-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0]     mcause_q, mcause_d;
    logic [0:0]          state_q, state_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic [63:0]         mcycle, minstret;
    logic [XLEN-1:0]     mstatus_rd, mie_rd, mip_rd;
    logic                csr_we;
    logic                irq_wake;
    logic [PC_WIDTH-1:0] tvec_base, trap_target;

    // ---------------- access checking ----------------
    assign csr_illegal = ((csr_rd_en | csr_wr_en) & ~csr_is_mapped(csr_addr))
                       | (csr_wr_en & ((csr_addr[11:10] == 2'b11)
                                      | (csr_addr == CSR_MISA)
                                      | (csr_addr == CSR_MIP)));
    assign csr_we = csr_wr_en & ~csr_illegal;

    // ---------------- read views ----------------
    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[12:11]        = 2'b11;          // MPP: machine mode only
        mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
        mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
        mie_rd                   = '0;
        mie_rd[IRQ_MEI]          = mie_q[2];
        mie_rd[IRQ_MTI]          = mie_q[1];
        mie_rd[IRQ_MSI]          = mie_q[0];
        mip_rd                   = '0;
        mip_rd[IRQ_MEI]          = ext_irq;
        mip_rd[IRQ_MTI]          = timer_irq;
        mip_rd[IRQ_MSI]          = sw_irq;
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rd_en) begin
            case (csr_addr)
                CSR_MSTATUS:  csr_rdata = mstatus_rd;
                CSR_MISA:     csr_rdata = XLEN'(MISA_VALUE);
                CSR_MIE:      csr_rdata = mie_rd;
                CSR_MTVEC:    csr_rdata = mtvec_q;
                CSR_MSCRATCH: csr_rdata = mscratch_q;
                CSR_MEPC:     csr_rdata = XLEN'(mepc_q);
                CSR_MCAUSE:   csr_rdata = mcause_q;
                CSR_MIP:      csr_rdata = mip_rd;
                CSR_MCYCLE:   csr_rdata = XLEN'(mcycle);
                CSR_MINSTRET: csr_rdata = XLEN'(minstret);
                default:      csr_rdata = '0;      // mtval, mhartid, unmapped
            endcase
        end
    end

    // ---------------- interrupt lines ----------------
    assign sip = mst_mie_q & mie_q[0] & sw_irq;
    assign tip = mst_mie_q & mie_q[1] & timer_irq;
    assign eip = mst_mie_q & mie_q[2] & ext_irq;

    // WFI wakes on any individually enabled pending line, ignoring mstatus.MIE
    assign irq_wake = (mie_q[2] & ext_irq) | (mie_q[1] & timer_irq) | (mie_q[0] & sw_irq);

    // ---------------- trap target ----------------
    assign tvec_base   = {mtvec_q[PC_WIDTH-1:2], 2'b00};
    assign trap_target = (mtvec_q[0] & interupt)
                       ? tvec_base + PC_WIDTH'({ecause, 2'b00})
                       : tvec_base;

    // ---------------- next-state ----------------
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        // Trap and mret own mstatus/mepc/mcause; a CSR write to those in the
        // same cycle is dropped, while writes elsewhere still commit below.
        if (trapped) begin
            mepc_d     = ecp & MEPC_MASK;
            mcause_d   = {interupt, {(XLEN-5){1'b0}}, ecause};
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = csr_wdata[MSTATUS_MIE];
                    mst_mpie_d = csr_wdata[MSTATUS_MPIE];
                end
                CSR_MEPC:   mepc_d   = csr_wdata[PC_WIDTH-1:0] & MEPC_MASK;
                CSR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (csr_we) begin
            case (csr_addr)
                CSR_MIE:      mie_d      = {csr_wdata[IRQ_MEI], csr_wdata[IRQ_MTI], csr_wdata[IRQ_MSI]};
                CSR_MTVEC:    mtvec_d    = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        redirect_valid_d = trapped | mret;
        redirect_pc_d    = redirect_pc_q;
        if (trapped) begin
            redirect_pc_d = trap_target;
        end else if (mret) begin
            redirect_pc_d = mepc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (wfi & ~trapped) state_d = ST_SLEEP;
            ST_SLEEP: if (irq_wake)       state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // NOTE: every register here holds architectural or control state, so all
    // of them are reset; there is no storage array that could skip reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mst_mie_q        <= 1'b0;
            mst_mpie_q       <= 1'b0;
            mie_q            <= '0;
            mtvec_q          <= XLEN'(RESET_MTVEC);
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mst_mie_q        <= mst_mie_d;
            mst_mpie_q       <= mst_mpie_d;
            mie_q            <= mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign sleeping       = (state_q == ST_SLEEP);

    // ---------------- counters ----------------
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rstn    (rstn),
        .inc_en  (1'b1),
        .wr_en   (csr_we & (csr_addr == CSR_MCYCLE)),
        .wr_data (64'(csr_wdata)),
        .count   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rstn    (rstn),
        .inc_en  (retired),
        .wr_en   (csr_we & (csr_addr == CSR_MINSTRET)),
        .wr_data (64'(csr_wdata)),
        .count   (minstret)
    );

endmodule

// File: tb/tb_csr_mtrap.sv
// ---------------------------------------------------------------------------
// tb_csr_mtrap
// Drives directed and random commit-time traffic into csr_mtrap. A driver
// pushes the expected per-cycle outputs and expected redirect targets into
// queues; a monitor compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_csr_mtrap;
    import csr_mtrap_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trapped = 0, mret = 0, wfi = 0, retired = 0;
    logic [31:0] ecp = '0;
    logic [3:0]  ecause = '0;
    logic        interupt = 0;
    logic        ext_irq = 0, timer_irq = 0, sw_irq = 0;
    logic        csr_rd_en = 0, csr_wr_en = 0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic        csr_illegal, sip, tip, eip, redirect_valid, sleeping;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    csr_mtrap #(.XLEN(64), .PC_WIDTH(32), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .rstn(rstn), .trapped(trapped), .mret(mret), .wfi(wfi),
        .retired(retired), .ecp(ecp), .ecause(ecause), .interupt(interupt),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .sip(sip), .tip(tip), .eip(eip), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .sleeping(sleeping)
    );

    typedef struct packed {
        logic        trapped, mret, wfi, retired;
        logic [31:0] ecp;
        logic [3:0]  ecause;
        logic        intr, rd, wr;
        logic [11:0] addr;
        logic [63:0] wdata;
    } stim_t;

    typedef struct packed {
        logic        rd;
        logic [63:0] rdata;
        logic        illegal, sip, tip, eip, sleeping, rv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] redir_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // irq levels and reset level held by the bench across steps
    logic ext_l = 0, tim_l = 0, sw_l = 0, rst_l = 0;

    // ---------------- reference model (architectural view) ----------------
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mcause, m_mcycle, m_minstret;
    logic [31:0] m_mepc;
    logic        m_sleep, m_rv;

    task automatic m_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 64'h100; m_mscratch = 0;
        m_mcause = 0; m_mcycle = 0; m_minstret = 0; m_mepc = 0;
        m_sleep = 0; m_rv = 0;
        redir_q.delete();
    endtask

    function automatic logic [63:0] m_mip();
        return (ext_l ? 64'h800 : 64'h0) | (tim_l ? 64'h80 : 64'h0) | (sw_l ? 64'h8 : 64'h0);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus | 64'h1800;
            12'h301: return MISA_VALUE;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return {32'h0, m_mepc};
            12'h342: return m_mcause;
            12'h344: return m_mip();
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic rd, input logic wr, input logic [11:0] a);
        logic mapped;
        mapped = a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                           12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14};
        return ((rd || wr) && !mapped) || (wr && (a[11:10] == 2'b11 || a == 12'h301 || a == 12'h344));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input stim_t s);
        exp_t        e;
        logic        we;
        logic [31:0] base, pc;
        logic        nsleep;
        @(posedge clk); #1;
        rstn = rst_l;
        trapped = s.trapped; mret = s.mret; wfi = s.wfi; retired = s.retired;
        ecp = s.ecp; ecause = s.ecause; interupt = s.intr;
        ext_irq = ext_l; timer_irq = tim_l; sw_irq = sw_l;
        csr_rd_en = s.rd; csr_wr_en = s.wr; csr_addr = s.addr; csr_wdata = s.wdata;
        if (!rst_l) m_reset();

        e.rd       = s.rd;
        e.rdata    = s.rd ? m_read(s.addr) : 64'h0;
        e.illegal  = m_illegal(s.rd, s.wr, s.addr);
        e.sip      = m_mstatus[3] & m_mie[3] & sw_l;
        e.tip      = m_mstatus[3] & m_mie[7] & tim_l;
        e.eip      = m_mstatus[3] & m_mie[11] & ext_l;
        e.sleeping = m_sleep;
        e.rv       = m_rv;
        exp_q.push_back(e);

        if (rst_l) begin
            we = s.wr && !e.illegal;
            if (!m_sleep) nsleep = s.wfi && !s.trapped;
            else          nsleep = !((m_mip() & m_mie) != 0);
            m_mcycle   = (we && s.addr == 12'hB00) ? s.wdata : m_mcycle + 1;
            m_minstret = (we && s.addr == 12'hB02) ? s.wdata : m_minstret + (s.retired ? 1 : 0);
            m_rv = s.trapped || s.mret;
            if (s.trapped) begin
                base = m_mtvec[31:0] & 32'hFFFF_FFFC;
                pc = (m_mtvec[0] && s.intr) ? base + 32'(s.ecause) * 4 : base;
                redir_q.push_back(pc);
                m_mepc    = s.ecp & 32'hFFFF_FFFC;
                m_mcause  = {s.intr, 59'h0, s.ecause};
                m_mstatus = m_mstatus[3] ? 64'h80 : 64'h0;
            end else if (s.mret) begin
                redir_q.push_back(m_mepc);
                m_mstatus = 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
            end else if (we) begin
                if (s.addr == 12'h300) m_mstatus = s.wdata & 64'h88;
                if (s.addr == 12'h341) m_mepc = s.wdata[31:0] & 32'hFFFF_FFFC;
                if (s.addr == 12'h342) m_mcause = s.wdata;
            end
            if (we && s.addr == 12'h304) m_mie = s.wdata & 64'h888;
            if (we && s.addr == 12'h305) m_mtvec = s.wdata & ~64'h2;
            if (we && s.addr == 12'h340) m_mscratch = s.wdata;
            m_sleep = nsleep;
        end
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        repeat (n) step(s);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        stim_t s;
        s = '0; s.wr = 1; s.addr = a; s.wdata = d;
        step(s);
    endtask

    task automatic csr_rd(input logic [11:0] a);
        stim_t s;
        s = '0; s.rd = 1; s.addr = a;
        step(s);
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [3:0] c, input logic intr, input logic do_mret);
        stim_t s;
        s = '0; s.trapped = 1; s.mret = do_mret; s.ecp = pc; s.ecause = c; s.intr = intr;
        step(s);
    endtask

    task automatic do_mret();
        stim_t s;
        s = '0; s.mret = 1;
        step(s);
    endtask

    task automatic do_reset();
        rst_l = 0;
        idle(2);
        rst_l = 1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.rd) check("csr_rdata", csr_rdata, e.rdata);
                check("csr_illegal", csr_illegal, e.illegal);
                check("sip", sip, e.sip);
                check("tip", tip, e.tip);
                check("eip", eip, e.eip);
                check("sleeping", sleeping, e.sleeping);
                check("redirect_valid", redirect_valid, e.rv);
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) check("redirect_expected", 64'(redir_q.size()), 64'd1);
                else                     check("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14,
                                   12'h7C0, 12'h306, 12'hC00, 12'hF11};

    initial begin
        stim_t s;
        m_reset();

        // reset held, then released
        rst_l = 0;
        csr_rd(12'h305);
        csr_rd(12'h300);
        rst_l = 1;
        csr_rd(12'h305);
        csr_rd(12'h300);

        // direct-mode exception
        csr_wr(12'h305, 64'h200);
        do_trap(32'h8000_1234, 4'd2, 1'b0, 1'b0);
        csr_rd(12'h341);
        csr_rd(12'h342);

        // vectored timer interrupt
        csr_wr(12'h305, 64'h201);
        csr_wr(12'h304, 64'h80);
        csr_wr(12'h300, 64'h8);
        tim_l = 1;
        idle(1);
        do_trap(32'h8000_2000, 4'd7, 1'b1, 1'b0);
        csr_rd(12'h342);
        csr_rd(12'h300);
        tim_l = 0;

        // mret, then trap and mret together (trap wins)
        do_mret();
        csr_rd(12'h300);
        do_trap(32'h8000_3004, 4'd3, 1'b0, 1'b1);
        csr_rd(12'h300);

        // CSR write alongside a trap: mscratch commits, mstatus is dropped
        s = '0; s.trapped = 1; s.ecp = 32'h100; s.ecause = 4'd5; s.wr = 1;
        s.addr = 12'h340; s.wdata = 64'hDEAD_BEEF_0000_1111;
        step(s);
        csr_rd(12'h340);
        s.addr = 12'h300; s.wdata = 64'h88;
        step(s);
        csr_rd(12'h300);

        // WFI with MIE=0: wakes on enabled external irq, eip stays 0
        csr_wr(12'h300, 64'h0);
        csr_wr(12'h304, 64'h800);
        s = '0; s.wfi = 1;
        step(s);
        idle(2);
        ext_l = 1;
        idle(2);
        ext_l = 0;

        // counter wrap, minstret, illegal accesses
        csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_rd(12'hB00);
        csr_rd(12'hB00);
        s = '0; s.retired = 1;
        repeat (3) step(s);
        csr_rd(12'hB02);
        csr_wr(12'hF14, 64'h1234);
        csr_rd(12'hF14);
        csr_rd(12'h7C0);
        csr_wr(12'h301, 64'h0);
        csr_wr(12'h344, 64'hFFF);
        csr_rd(12'h301);

        // reset mid-operation: pending redirect and sleep are aborted
        csr_wr(12'h304, 64'h0);
        s = '0; s.wfi = 1;
        step(s);
        do_trap(32'h4000_0000, 4'd1, 1'b0, 1'b0);
        do_reset();
        csr_rd(12'h305);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.trapped = ($urandom_range(15) == 0);
            s.mret    = ($urandom_range(15) == 0);
            s.wfi     = ($urandom_range(23) == 0);
            s.retired = $urandom_range(1);
            s.ecp     = $urandom;
            s.ecause  = 4'($urandom);
            s.intr    = $urandom_range(1);
            s.rd      = $urandom_range(1);
            s.wr      = ($urandom_range(3) == 0);
            s.addr    = addr_tab[$urandom_range(15)];
            s.wdata   = {$urandom, $urandom};
            if ($urandom_range(7) == 0) ext_l = ~ext_l;
            if ($urandom_range(7) == 0) tim_l = ~tim_l;
            if ($urandom_range(7) == 0) sw_l  = ~sw_l;
            if ($urandom_range(999) == 0) do_reset();
            step(s);
        end

        idle(3);
        @(negedge clk); #1;
        check("redirect_leftover", 64'(redir_q.size()), 64'd0);
        check("expect_leftover", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
